// File: rtl/fsm_pkg.sv
// Shared definitions for the 6502 instruction-cycle sequencer: addressing-mode
// codes, one-hot state bit positions and the state encoding built from them.
package fsm_pkg;

  localparam int MODE_W = 3;

  localparam logic [MODE_W-1:0] MODE_IMP  = 3'd0;
  localparam logic [MODE_W-1:0] MODE_ZP   = 3'd1;
  localparam logic [MODE_W-1:0] MODE_ZPY  = 3'd2;
  localparam logic [MODE_W-1:0] MODE_ABS  = 3'd3;
  localparam logic [MODE_W-1:0] MODE_ABSI = 3'd4;
  localparam logic [MODE_W-1:0] MODE_IND  = 3'd5;

  localparam int ST_W   = 7;
  localparam int ST_S0  = 0;
  localparam int ST_SOP = 1;
  localparam int ST_SLO = 2;
  localparam int ST_SHI = 3;
  localparam int ST_SIN = 4;
  localparam int ST_SCO = 5;
  localparam int ST_SLR = 6;

  typedef enum logic [ST_W-1:0] {
    STATE_S0  = ST_W'(1 << ST_S0),
    STATE_SOP = ST_W'(1 << ST_SOP),
    STATE_SLO = ST_W'(1 << ST_SLO),
    STATE_SHI = ST_W'(1 << ST_SHI),
    STATE_SIN = ST_W'(1 << ST_SIN),
    STATE_SCO = ST_W'(1 << ST_SCO),
    STATE_SLR = ST_W'(1 << ST_SLR)
  } state_e;

  // Codes 6 and 7 have no addressing sequence; they run as a two-cycle no-op.
  function automatic logic mode_is_illegal(input logic [MODE_W-1:0] mode);
    return mode > MODE_IND;
  endfunction

endpackage

// File: rtl/fsm_state.sv
// 6502 instruction-cycle sequencer: one-hot state strobes, in-instruction cycle
// index and a sticky illegal-mode flag, all driven straight from flops.
module fsm_state
  import fsm_pkg::*;
#(
  parameter int CYC_W = 3
) (
  input  logic [4:0]       LOGISIM_CLOCK_TREE_0,
  input  logic             RST,
  input  logic             RDY,
  input  logic [2:0]       MODE,
  input  logic             CO,
  output logic             S0,
  output logic             SOP,
  output logic             SLO,
  output logic             SHI,
  output logic             SIN,
  output logic             SCO,
  output logic             SLR,
  output logic             SYNC,
  output logic [CYC_W-1:0] CYC,
  output logic             ILL
);

  logic w_clk;
  logic w_tick;
  logic w_adv;
  logic w_unused_clk_bits;

  assign w_clk             = LOGISIM_CLOCK_TREE_0[4];
  assign w_tick            = LOGISIM_CLOCK_TREE_0[2];
  assign w_unused_clk_bits = ^{LOGISIM_CLOCK_TREE_0[3], LOGISIM_CLOCK_TREE_0[1:0]};
  assign w_adv             = w_tick & RDY;

  logic [ST_W-1:0]   r_state;
  logic [MODE_W-1:0] r_mreg;
  logic [CYC_W-1:0]  r_cyc;
  logic              r_ill;

  logic [ST_W-1:0]   w_state_nxt;
  logic [MODE_W-1:0] w_mreg_nxt;
  logic [CYC_W-1:0]  w_cyc_nxt;
  logic              w_ill_nxt;

  // NOTE: every signal gets its hold value before the case, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_mreg_nxt  = r_mreg;
    w_cyc_nxt   = r_cyc;
    w_ill_nxt   = r_ill;

    if (w_adv) begin
      case (r_state)
        STATE_S0: begin
          w_mreg_nxt = MODE;
          if (mode_is_illegal(MODE)) begin
            w_ill_nxt   = 1'b1;
            w_state_nxt = STATE_SOP;
          end else if (MODE == MODE_IMP) begin
            w_state_nxt = STATE_SOP;
          end else begin
            w_state_nxt = STATE_SLO;
          end
        end
        STATE_SOP: w_state_nxt = STATE_S0;
        STATE_SLO: begin
          if (r_mreg == MODE_ZP || r_mreg == MODE_ZPY) begin
            w_state_nxt = STATE_SLR;
          end else if (r_mreg == MODE_IND) begin
            w_state_nxt = STATE_SIN;
          end else begin
            w_state_nxt = STATE_SHI;
          end
        end
        STATE_SIN: w_state_nxt = STATE_SHI;
        // Page-crossing fix-up cycle only exists for the indexed modes.
        STATE_SHI: begin
          if ((r_mreg == MODE_ABSI || r_mreg == MODE_IND) && CO) begin
            w_state_nxt = STATE_SCO;
          end else begin
            w_state_nxt = STATE_SLR;
          end
        end
        STATE_SCO: w_state_nxt = STATE_SLR;
        STATE_SLR: w_state_nxt = STATE_S0;
        // Zero or several bits set: recover to the fetch cycle without using mreg.
        default:   w_state_nxt = STATE_S0;
      endcase

      if (w_state_nxt == STATE_S0) begin
        w_cyc_nxt = '0;
      end else if (r_cyc != {CYC_W{1'b1}}) begin
        w_cyc_nxt = r_cyc + CYC_W'(1);
      end
    end
  end

  // NOTE: state flops use non-blocking assignments so every register samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge w_clk) begin
    if (RST) begin
      r_state <= STATE_S0;
      r_mreg  <= MODE_IMP;
      r_cyc   <= '0;
      r_ill   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_mreg  <= w_mreg_nxt;
      r_cyc   <= w_cyc_nxt;
      r_ill   <= w_ill_nxt;
    end
  end

  assign S0   = r_state[ST_S0];
  assign SOP  = r_state[ST_SOP];
  assign SLO  = r_state[ST_SLO];
  assign SHI  = r_state[ST_SHI];
  assign SIN  = r_state[ST_SIN];
  assign SCO  = r_state[ST_SCO];
  assign SLR  = r_state[ST_SLR];
  assign SYNC = r_state[ST_S0];
  assign CYC  = r_cyc;
  assign ILL  = r_ill;

endmodule
